// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared BTB entry type, sizing and counter helpers
package branch_predictor_pkg;

    localparam int TAG_MAX_W = 30;
    localparam int CTR_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [CTR_MAX_W-1:0] ctr;
    } btb_entry_t;

    function automatic int calc_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int weak_taken(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// sat_counter: saturating up/down direction counter with synchronous load
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] cnt
);

    logic [CTR_W-1:0] cnt_d, cnt_q;

    // load wins; otherwise step, holding at all-ones or zero
    always_comb begin
        cnt_d = load ? load_val :
                (inc && ~&cnt_q) ? cnt_q + 1'b1 :
                (dec && |cnt_q) ? cnt_q - 1'b1 : cnt_q;
    end

    // counter state
    always_ff @(posedge CLK) begin
        cnt_q <= RST ? '0 : cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating counters; stats via BRANCH_PREDICTOR_STATS_EN
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc,
    input  logic        lookup_en,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    input  logic        flush_all,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispredicts
);

    localparam int IDX_W = calc_idx_w(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] WEAK = CTR_W'(weak_taken(CTR_W));

    logic [ENTRIES-1:0] valid_d, valid_q;
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr [ENTRIES];
    btb_entry_t         tbl [ENTRIES];
    btb_entry_t         ent;
    logic [IDX_W-1:0]   idx, uidx;
    logic [TAG_W-1:0]   tag, utag;
    logic               hit, uhit, upd_go;

    assign idx  = pc[IDX_W+1:2];
    assign tag  = pc[31:IDX_W+2];
    assign uidx = upd_pc[IDX_W+1:2];
    assign utag = upd_pc[31:IDX_W+2];

    assign ent         = tbl[idx];
    assign hit         = ent.valid && ent.tag == TAG_MAX_W'(tag);
    assign pred_taken  = hit && ent.ctr >= CTR_MAX_W'(WEAK);
    assign pred_target = pred_taken ? ent.target : pc + 32'd4;

    assign mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target));
    assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    // a flush in the same cycle discards the update
    assign uhit   = valid_q[uidx] && tag_q[uidx] == utag;
    assign upd_go = upd_valid && !flush_all;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        logic sel;
        assign sel = upd_go && uidx == IDX_W'(g);
        sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .CLK      (CLK),
            .RST      (RST),
            .load     (sel && !uhit && upd_taken),
            .load_val (WEAK),
            .inc      (sel && uhit && upd_taken),
            .dec      (sel && uhit && !upd_taken),
            .cnt      (ctr[g])
        );
        assign tbl[g] = '{valid: valid_q[g], tag: TAG_MAX_W'(tag_q[g]), target: target_q[g], ctr: CTR_MAX_W'(ctr[g])};
    end

    // flush clears valids; any taken resolution (re)writes tag and target, allocating on a miss
    always_comb begin
        valid_d  = flush_all ? '0 : valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_go && upd_taken) begin
            valid_d[uidx]  = 1'b1;
            tag_d[uidx]    = utag;
            target_d[uidx] = upd_target;
        end
    end

    // table state
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q  <= '0;
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] lookups_d, lookups_q, hits_d, hits_q, misp_d, misp_q;

    // saturating event counters, untouched by flush
    always_comb begin
        lookups_d = lookups_q + 32'(lookup_en && ~&lookups_q);
        hits_d    = hits_q + 32'(lookup_en && hit && ~&hits_q);
        misp_d    = misp_q + 32'(mispredict && ~&misp_q);
    end

    // statistics state
    always_ff @(posedge CLK) begin
        lookups_q <= RST ? '0 : lookups_d;
        hits_q    <= RST ? '0 : hits_d;
        misp_q    <= RST ? '0 : misp_d;
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = misp_q;
`else
    logic stats_unused;
    assign stats_unused     = lookup_en;
    assign stat_lookups     = '0;
    assign stat_hits        = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan plus random traffic against a behavioural BTB model
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, lookup_en, upd_valid, upd_taken, upd_pred_taken, flush_all;
    logic [31:0] pc, upd_pc, upd_target, upd_pred_target;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, correct_pc, stat_lookups, stat_hits, stat_mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    // model: one record per slot, slot = word address mod 16, tag = address / 64
    bit          armed = 1'b0;
    bit          m_valid [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];
    int unsigned m_lk, m_hit, m_mp;

    branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .pc              (pc),
        .lookup_en       (lookup_en),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .flush_all       (flush_all),
        .stat_lookups    (stat_lookups),
        .stat_hits       (stat_hits),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit m_hits(input logic [31:0] a);
        return m_valid[slot(a)] && m_tag[slot(a)] == (a >> 6);
    endfunction

    function automatic bit m_ptaken(input logic [31:0] a);
        return m_hits(a) && m_ctr[slot(a)] >= 2;
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] a);
        return m_ptaken(a) ? m_tgt[slot(a)] : a + 32'd4;
    endfunction

    task automatic cycle();
        bit lhit, uhit, misp;
        int s;
        #2;
        lhit = m_hits(pc);
        misp = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target));
        if (armed) begin
            chk("pred_taken", 32'(pred_taken), 32'(m_ptaken(pc)));
            chk("pred_target", pred_target, m_ptarget(pc));
            chk("mispredict", 32'(mispredict), 32'(misp));
            chk("correct_pc", correct_pc, upd_taken ? upd_target : upd_pc + 32'd4);
            chk("stat_lookups", stat_lookups, STATS ? m_lk : 32'd0);
            chk("stat_hits", stat_hits, STATS ? m_hit : 32'd0);
            chk("stat_mispredicts", stat_mispredicts, STATS ? m_mp : 32'd0);
        end
        uhit = m_hits(upd_pc);
        s = slot(upd_pc);
        @(posedge CLK);
        if (RST) begin
            armed = 1'b1;
            m_lk = 0; m_hit = 0; m_mp = 0;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
            end
        end else begin
            if (lookup_en && m_lk != 32'hFFFFFFFF) m_lk++;
            if (lookup_en && lhit && m_hit != 32'hFFFFFFFF) m_hit++;
            if (misp && m_mp != 32'hFFFFFFFF) m_mp++;
            if (flush_all) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                if (uhit && upd_taken) begin
                    m_ctr[s] = m_ctr[s] == 3 ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = upd_target;
                end else if (uhit) begin
                    m_ctr[s] = m_ctr[s] == 0 ? 0 : m_ctr[s] - 1;
                end else if (upd_taken) begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = upd_pc >> 6;
                    m_tgt[s]   = upd_target;
                    m_ctr[s]   = 2;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic drive(input logic r, input logic fl, input logic le, input logic [31:0] p,
                         input logic uv, input logic [31:0] up, input logic ut, input logic [31:0] utg,
                         input logic upt, input logic [31:0] uptg);
        RST = r; flush_all = fl; lookup_en = le; pc = p;
        upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
        upd_pred_taken = upt; upd_pred_target = uptg;
        cycle();
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] a;
        if ($urandom_range(0, 31) == 0) return 32'hFFFFFFFC;
        a = '0;
        a[5:2] = 4'($urandom_range(0, 15));
        a[7:6] = 2'($urandom_range(0, 3));
        a[31]  = 1'($urandom_range(0, 1));
        return a;
    endfunction

    initial begin
        logic [31:0] up;
        bit pt;
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        chk("reset_pred_target_abs", pred_target, 32'h4);
        repeat (3) drive(0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0);
        drive(0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        repeat (2) drive(0, 0, 0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
        drive(0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        repeat (4) drive(0, 0, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0);
        drive(0, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
        drive(0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 1, 32'h440, 1, 32'h440, 1, 32'h200, 0, 32'h0);
        drive(0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 1, 32'h440, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 1, 0, 32'h440, 1, 32'h80, 1, 32'h300, 0, 32'h0);
        drive(0, 0, 1, 32'h440, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 1, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 32'h8);
        chk("wrap_correct_pc_abs", correct_pc, 32'h0);
        drive(0, 0, 0, 32'h0, 1, 32'hC0, 1, 32'h500, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 1, 32'hC0, 1, 32'h600, 0, 32'h0);
        drive(0, 0, 1, 32'hC0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            up = rnd_pc();
            pt = $urandom_range(0, 1) == 1;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), rnd_pc(),
                  1'($urandom_range(0, 1)), up, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 3) * 64), 2'b00},
                  pt ? m_ptaken(up) : 1'($urandom_range(0, 1)), pt ? m_ptarget(up) : {22'd0, 8'($urandom_range(0, 3) * 64), 2'b00});
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with saturating direction counters that supplies a predicted next PC at fetch and is trained by branches and jumps resolved in MEM. It extends the pipeline's fixed PC+4 fetch with a registered, direct-mapped prediction table. The fetch mux uses `pred_target` when `pred_taken` is set, and takes `correct_pc` on `mispredict`. The block is sequential storage with combinational lookup; all state changes occur at the rising edge of `CLK`.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of two, at least 2.
- CTR_W, 2, width of each direction counter; at least 1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- pc  in  32  current fetch PC, word-aligned.
- lookup_en  in  1  fetch advancing this cycle (ihit and PC enable).
- pred_taken  out  1  prediction for `pc`: taken.
- pred_target  out  32  predicted target; equals `pc+4` when not taken.
- upd_valid  in  1  a control-transfer instruction resolved in MEM this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction of the resolved instruction.
- upd_target  in  32  actual taken target of the resolved instruction.
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  32  predicted target carried down the pipe.
- mispredict  out  1  redirect fetch and flush the younger stages.
- correct_pc  out  32  redirect address.
- flush_all  in  1  invalidate the whole table.
- stat_lookups, stat_hits, stat_mispredicts  out  32 each  statistics counters.

## Operation
- IDX_W = log2(ENTRIES).
- Index is `pc[IDX_W+1:2]`.
- Tag is `pc[31:IDX_W+2]`, giving TAG_W = 30-IDX_W.
- Each entry holds: valid, tag, target[31:0], ctr[CTR_W-1:0].

Lookup (combinational):
- hit = valid[idx] & (tag[idx] == pc tag).
- pred_taken = hit & ctr[idx][CTR_W-1].
- pred_target = pred_taken ? target[idx] : pc+4.

Resolution (combinational):
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target))).
- correct_pc = upd_taken ? upd_target : upd_pc+4.

Update (registered), applied to the entry selected by `upd_pc`:
- Update hit, taken: ctr increments, saturating at all-ones; target is written with `upd_target`.
- Update hit, not taken: ctr decrements, saturating at 0; target is unchanged.
- Update miss, taken: the entry is allocated or replaced. valid=1, tag written, target=upd_target, ctr = weakly-taken (MSB=1, all other bits 0).
- Update miss, not taken: no change to the table.

Priority: RST > flush_all > update. flush_all clears every valid bit; ctr and target bits are don't-care after a flush.

## Timing
- Lookup latency is 0 cycles (combinational from `pc`).
- Update takes effect at the next rising edge and is visible to a lookup one cycle after `upd_valid`.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents.
- mispredict and correct_pc are valid in the same cycle as upd_valid.
- Address wrap: pc+4 and upd_pc+4 wrap modulo 2^32 (0xFFFFFFFC+4 = 0).
- Reset values:
  - all valid bits 0, all ctr bits 0, all targets 0.
  - stat counters 0.
  - Outputs with `pc`=0 and no update: pred_taken=0, pred_target=4, mispredict=0, correct_pc=upd_pc+4.
- Reset asserted mid-update: the update is discarded.

## Configuration
- BRANCH_PREDICTOR_STATS_EN defined:
  - stat_lookups increments on lookup_en.
  - stat_hits increments on lookup_en & hit.
  - stat_mispredicts increments on mispredict.
  - Each counter is 32 bits and saturates at 0xFFFFFFFF.
  - Counters are cleared by RST only, not by flush_all.
- Not defined: no counter flops are built and all stat outputs are tied to 0.

## Structure
- dp_types_pkg: btb_entry_t struct (valid, tag, target, ctr).
- dp_types_pkg: constant for weakly-taken initialisation.
- dp_types_pkg: function computing IDX_W from ENTRIES.
- One sub-module, sat_counter (parameter CTR_W; inputs inc and dec; saturating), instantiated once per entry in a generate loop.

## Test plan
- Run with ENTRIES=16.
- After reset, pc=0x40 -> pred_taken=0, pred_target=0x44; after 3 cycles with lookup_en high (`BRANCH_PREDICTOR_STATS_EN` defined), stat_lookups=3.
- Update pc=0x40, taken=1, target=0x100, pred_taken=0:
  - same cycle: mispredict=1, correct_pc=0x100.
  - next cycle, lookup 0x40: pred_taken=1, pred_target=0x100.
- With the entry from the previous scenario (ctr=10), two not-taken updates (ctr 10 -> 01 -> 00):
  - lookup 0x40 gives pred_taken=0.
  - three further taken updates leave the entry saturated at 11.
- Aliasing:
  - pc=0x440 (same index as 0x40, different tag) -> miss, pred_taken=0.
  - a taken update at 0x440 replaces the entry; a later lookup at 0x40 then misses.
- Assert flush_all and an update in the same cycle -> all entries invalid next cycle; the update is discarded.
- Update upd_pc=0xFFFFFFFC, taken=0, pred_taken=1 -> mispredict=1, correct_pc=0x00000000.
